// File: rtl/turn_controller_if.sv
// rtl/turn_controller_if.sv - turn/card/strobe link between turn controller and win checker
interface turn_controller_if;
  logic [1:0] T;       // current player turn
  logic [4:0] N;       // card latched at press
  logic       B;       // one-cycle move strobe
  logic       W;       // match flag back from the checker
  logic [4:0] pos_in;  // mover's position after the move

  // Controller side: drives turn/card/strobe, reads the checker's verdict.
  modport master (
    output T,
    output N,
    output B,
    input  W,
    input  pos_in
  );

  // Checker side.
  modport slave (
    input  T,
    input  N,
    input  B,
    output W,
    output pos_in
  );
endinterface

// File: rtl/turn_controller.sv
// rtl/turn_controller.sv - button conditioning and turn FSM driving the win checker
module turn_controller #(
  parameter int DEB_CYCLES  = 4,
  parameter int EVAL_WAIT   = 2,
  parameter int NUM_PLAYERS = 4,
  parameter int GOAL_POS    = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_raw,
  input  logic [4:0]        card_in,
  turn_controller_if.master chk,
  output logic              busy,
  output logic              invalid_card,
  output logic              game_over,
  output logic [1:0]        winner
);

  localparam int DEB_W  = $clog2(DEB_CYCLES) + 1;
  localparam int WAIT_W = $clog2(EVAL_WAIT) + 1;

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(EVAL_WAIT - 1);
  localparam logic [1:0]        LAST_T    = 2'(NUM_PLAYERS - 1);
  localparam logic [4:0]        GOAL      = 5'(GOAL_POS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRE,
    S_WAIT,
    S_JUDGE,
    S_OVER
  } state_t;

  // Input conditioning registers
  logic             sync1_q;
  logic             sync2_q;
  logic             deb_q;
  logic             deb_prev_q;
  logic [DEB_W-1:0] deb_cnt_q;
  logic             press_q;

  // FSM registers
  state_t            state_q,   state_d;
  logic [1:0]        t_q,       t_d;
  logic [4:0]        n_q,       n_d;
  logic [WAIT_W-1:0] wait_q,    wait_d;
  logic              over_q,    over_d;
  logic [1:0]        winner_q,  winner_d;
  logic              invalid_q, invalid_d;

  // Synchronise the button, debounce it, and register a one-cycle press pulse
  // on the debounced rising edge. The press pulse is registered so the FSM sees
  // it one cycle after the debounced level rises; releases produce nothing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      deb_cnt_q  <= '0;
      press_q    <= 1'b0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      press_q    <= deb_q & ~deb_prev_q;
      if (sync2_q == deb_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q == DEB_LAST) begin
        deb_q     <= ~deb_q;
        deb_cnt_q <= '0;
      end else begin
        deb_cnt_q <= deb_cnt_q + 1'b1;
      end
    end
  end

  // FSM and game-state registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      t_q       <= 2'd0;
      n_q       <= 5'd0;
      wait_q    <= '0;
      over_q    <= 1'b0;
      winner_q  <= 2'd0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      n_q       <= n_d;
      wait_q    <= wait_d;
      over_q    <= over_d;
      winner_q  <= winner_d;
      invalid_q <= invalid_d;
    end
  end

  // Next-state logic: accept a press, strobe the checker, wait, then judge.
  // Presses outside IDLE are simply not looked at, so they are dropped.
  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    n_d       = n_q;
    wait_d    = wait_q;
    over_d    = over_q;
    winner_d  = winner_q;
    invalid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (press_q) begin
          if (card_in != 5'd0) begin
            n_d     = card_in;
            state_d = S_FIRE;
          end else begin
            invalid_d = 1'b1;
          end
        end
      end

      S_FIRE: begin
        wait_d  = WAIT_LOAD;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (wait_q == '0) begin
          state_d = S_JUDGE;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end

      S_JUDGE: begin
        if (chk.pos_in >= GOAL) begin
          over_d   = 1'b1;
          winner_d = t_q;
          state_d  = S_OVER;
        end else if (chk.W) begin
          // Matching card: the same player moves again.
          state_d = S_IDLE;
        end else begin
          t_d     = (t_q == LAST_T) ? 2'd0 : t_q + 2'd1;
          state_d = S_IDLE;
        end
      end

      S_OVER: begin
        state_d = S_OVER;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign chk.T        = t_q;
  assign chk.N        = n_q;
  assign chk.B        = (state_q == S_FIRE);
  assign busy         = (state_q != S_IDLE);
  assign invalid_card = invalid_q;
  assign game_over    = over_q;
  assign winner       = winner_q;

endmodule
